// File: rtl/tns_pkg.sv
// Shared constants and per-group symbol maps for the 24-wire TSV crosstalk codec.
// Imported by the encoder top and by the standalone receive-side decoder.
package tns_pkg;

   localparam int DATA_W = 23;
   localparam int GROUPS = 8;
   localparam int TSV_W  = 3 * GROUPS;

   localparam logic [DATA_W-1:0] TNS_C = 23'd5_764_801;
   localparam logic [DATA_W-1:0] SEVEN = 23'd7;

   localparam logic [DATA_W-1:0] POW7 [GROUPS] = '{
      23'd1, 23'd7, 23'd49, 23'd343,
      23'd2_401, 23'd16_807, 23'd117_649, 23'd823_543
   };

   // s is the group's previously driven b2; the skipped pattern is the one
   // whose b2 toggle would oppose both lower wires (100 from 0, 011 from 1).
   function automatic logic [2:0] tns_enc_sym(input logic [2:0] d, input logic s);
      logic [2:0] p;
      if (s) p = (d < 3'd3) ? d : d + 3'd1;
      else   p = (d < 3'd4) ? d : d + 3'd1;
      return p;
   endfunction

   // Patterns 3 and 4 both stand for digit 3, so no state is needed to decode.
   function automatic logic [2:0] tns_dec_sym(input logic [2:0] p);
      logic [2:0] d;
      if (p <= 3'd2)      d = p;
      else if (p <= 3'd4) d = 3'd3;
      else                d = p - 3'd1;
      return d;
   endfunction

endpackage

// File: rtl/tns_dec_24.sv
// Combinational, state-free decoder: 8 base-7 digits on the TSV bundle back to binary.
// Usable on its own on the receiving die.
module tns_dec_24
   import tns_pkg::*;
(
   input  logic [TSV_W-1:0]  tsv,
   output logic [DATA_W-1:0] dataout
);

   logic [DATA_W-1:0] acc;

   always_comb begin
      acc = '0;
      for (int j = 0; j < GROUPS; j++) begin
         acc = acc + DATA_W'(tns_dec_sym(tsv[3*j +: 3])) * POW7[j];
      end
   end

   assign dataout = acc;

endmodule

// File: rtl/tns_codec_24.sv
// Registered base-7 TSV encoder with the combinational decoder on its output.
// Out-of-range words leave the bundle (and hence the decoded word) unchanged.
module tns_codec_24
   import tns_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] datain,
   output logic [TSV_W-1:0]  tsv,
   output logic [DATA_W-1:0] dataout
);

   logic [DATA_W-1:0] quot [GROUPS+1];
   logic [2:0]        dig  [GROUPS];
   logic [TSV_W-1:0]  tsv_nxt;
   logic              in_range;

   assign quot[0]  = datain;
   assign in_range = (datain < TNS_C);

   // Successive constant divides peel off digits, least significant first.
   for (genvar j = 0; j < GROUPS; j++) begin : g_digit
      assign quot[j+1] = quot[j] / SEVEN;
      assign dig[j]    = 3'(quot[j] % SEVEN);
      assign tsv_nxt[3*j +: 3] = tns_enc_sym(dig[j], tsv[3*j+2]);
   end

   always_ff @(posedge clock) begin
      if (reset)         tsv <= '0;
      else if (in_range) tsv <= tsv_nxt;
   end

   tns_dec_24 u_dec (
      .tsv     (tsv),
      .dataout (dataout)
   );

endmodule

// File: tb/tb_tns_codec_24.sv
// Bench for tns_codec_24: directed cases with fixed expectations, then random
// in-range words against an arithmetic reference model of the codec.
module tb_tns_codec_24;
   import tns_pkg::*;

   logic              clock;
   logic              reset;
   logic [DATA_W-1:0] datain;
   logic [TSV_W-1:0]  tsv;
   logic [DATA_W-1:0] dataout;

   int n_cmp = 0;
   int n_err = 0;

   logic [DATA_W-1:0] exp_q [$];
   logic [TSV_W-1:0]  m_tsv;
   int unsigned       m_data;

   tns_codec_24 dut (
      .clock   (clock),
      .reset   (reset),
      .datain  (datain),
      .tsv     (tsv),
      .dataout (dataout)
   );

   // ---------------- clock / reset ----------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ---------------- scoreboard ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: split the word into base-7 digits with integer arithmetic and
   // pick each pattern from the digit and the group's previous top wire,
   // skipping the one forbidden pattern for that previous value.
   function automatic logic [TSV_W-1:0] ref_encode(input logic [TSV_W-1:0] prev,
                                                   input int unsigned v);
      logic [TSV_W-1:0] r;
      int unsigned rem, d, p, forbidden;
      rem = v;
      r   = '0;
      for (int j = 0; j < GROUPS; j++) begin
         d   = rem % 7;
         rem = rem / 7;
         forbidden = prev[3*j+2] ? 3 : 4;
         p = (d < forbidden) ? d : d + 1;
         r[3*j +: 3] = p[2:0];
      end
      return r;
   endfunction

   // ---------------- drivers ----------------
   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset  = 1'b0;
      m_tsv  = '0;
      m_data = 0;
      check("reset_tsv", 32'(tsv), 32'h0);
      check("reset_dataout", 32'(dataout), 32'd0);
   endtask

   task automatic drive(input int unsigned v);
      logic [TSV_W-1:0] prev;
      logic [2:0]       p;
      int               bad;
      datain = DATA_W'(v);
      prev   = tsv;
      @(posedge clock);
      #1;
      if (v < 32'(TNS_C)) begin
         m_tsv  = ref_encode(m_tsv, v);
         m_data = v;
      end
      exp_q.push_back(DATA_W'(m_data));
      bad = 0;
      for (int j = 0; j < GROUPS; j++) begin
         p = tsv[3*j +: 3];
         if (!prev[3*j+2] && p == 3'b100) bad++;
         if ( prev[3*j+2] && p == 3'b011) bad++;
      end
      check("tsv_model", 32'(tsv), 32'(m_tsv));
      check("dataout_model", 32'(dataout), 32'(exp_q.pop_front()));
      check("crosstalk", 32'(bad), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset  = 1'b1;
      datain = '0;
      m_tsv  = '0;
      m_data = 0;
      repeat (2) @(posedge clock);
      #1;
      apply_reset();

      // single low digit, both previous-wire states
      drive(3);
      check("low3_tsv", 32'(tsv), 32'h000003);
      check("low3_dout", 32'(dataout), 32'd3);
      drive(6);
      check("low6_tsv", 32'(tsv[2:0]), 32'b111);
      check("low6_dout", 32'(dataout), 32'd6);
      drive(3);
      check("low3_s1_tsv", 32'(tsv[2:0]), 32'b100);
      check("low3_s1_dout", 32'(dataout), 32'd3);

      // all digits 3 from state 0, all 6, all 3 from state 1
      apply_reset();
      drive(2_882_400);
      check("all3_s0_tsv", 32'(tsv), 32'h6DB6DB);
      check("all3_s0_dout", 32'(dataout), 32'd2_882_400);
      drive(5_764_800);
      check("all6_tsv", 32'(tsv), 32'hFFFFFF);
      check("all6_dout", 32'(dataout), 32'd5_764_800);
      drive(2_882_400);
      check("all3_s1_tsv", 32'(tsv), 32'h924924);
      check("all3_s1_dout", 32'(dataout), 32'd2_882_400);

      // out of range holds the bundle
      drive(5_764_800);
      drive(5_764_801);
      check("oor_tsv", 32'(tsv), 32'hFFFFFF);
      check("oor_dout", 32'(dataout), 32'd5_764_800);
      drive(8_388_607);
      check("oor_max_tsv", 32'(tsv), 32'hFFFFFF);

      // reset mid-stream
      apply_reset();
      check("midrst_tsv", 32'(tsv), 32'h0);
      drive(3);
      check("midrst_next_tsv", 32'(tsv), 32'h000003);

      // random stress over the valid range
      for (int i = 0; i < 20000; i++) begin
         drive($urandom_range(32'(TNS_C) - 1, 0));
      end
      // a sprinkling of out-of-range words between valid ones
      for (int i = 0; i < 200; i++) begin
         drive($urandom_range(32'(TNS_C) - 1, 0));
         drive($urandom_range(8_388_607, 32'(TNS_C)));
      end

      // ---------------- report ----------------
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
